// File: rtl/dphy_tx_pkg.sv
// D-PHY HS transmit lane: state encodings and LP line-level constants.
package dphy_tx_pkg;

    typedef logic [2:0] dphyState_t;

    localparam logic [2:0] ST_STOP     = 3'd0;
    localparam logic [2:0] ST_HS_RQST  = 3'd1;
    localparam logic [2:0] ST_HS_PREP  = 3'd2;
    localparam logic [2:0] ST_HS_ZERO  = 3'd3;
    localparam logic [2:0] ST_HS_SYNC  = 3'd4;
    localparam logic [2:0] ST_HS_DATA  = 3'd5;
    localparam logic [2:0] ST_HS_TRAIL = 3'd6;
    localparam logic [2:0] ST_HS_EXIT  = 3'd7;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hB8;

    // {Dp, Dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

endpackage

// File: rtl/dphy_phase_timer.sv
// Loadable down-counter shared by all timed phases of the HS sequencer.
module dphy_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             byteClk,
    input  logic             rstN,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge byteClk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/dphy_hs_tx_sequencer.sv
// Sequences one D-PHY data lane through LP-11/LP-01/LP-00, HS preamble,
// payload and trail, driving LP levels, HS enables and the serializer byte.
module dphy_hs_tx_sequencer
    import dphy_tx_pkg::*;
#(
    parameter int         T_LPX      = 2,
    parameter int         T_HS_PREP  = 2,
    parameter int         T_HS_ZERO  = 6,
    parameter int         T_HS_TRAIL = 3,
    parameter int         T_HS_EXIT  = 4,
    parameter int         CNT_W      = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic       TxByteClk,
    input  logic       TxRst,
    input  logic       TxRequestHS,
    input  logic [7:0] TxDataHS,
    output logic       TxReadyHS,
    output logic       LpDp,
    output logic       LpDn,
    output logic       LptxEn,
    output logic       HstxEn,
    output logic       HsclkEn,
    output logic [7:0] HsData,
    output logic [2:0] DphyTxState,
    output logic       TxStopState
);

    dphyState_t       state;
    dphyState_t       nextState;
    logic             timerLoad;
    logic             timerExpired;
    logic [CNT_W-1:0] timerVal;
    logic [7:0]       hsDataD;
    logic [7:0]       hsDataQ;
    logic             lastBit;
    logic             accept;
    logic [1:0]       lpLevel;

    assign accept    = (state == ST_HS_DATA) && TxRequestHS;
    assign TxReadyHS = accept;

    always_comb begin
        nextState = state;
        unique case (state)
            ST_STOP:     if (TxRequestHS)  nextState = ST_HS_RQST;
            ST_HS_RQST:  if (timerExpired) nextState = ST_HS_PREP;
            ST_HS_PREP:  if (timerExpired) nextState = ST_HS_ZERO;
            ST_HS_ZERO:  if (timerExpired) nextState = ST_HS_SYNC;
            ST_HS_SYNC:                    nextState = ST_HS_DATA;
            ST_HS_DATA:  if (!TxRequestHS) nextState = ST_HS_TRAIL;
            ST_HS_TRAIL: if (timerExpired) nextState = ST_HS_EXIT;
            ST_HS_EXIT:  if (timerExpired) nextState = ST_STOP;
        endcase
    end

    // Timer reloads on every transition; untimed states ignore it.
    assign timerLoad = (nextState != state);

    always_comb begin
        timerVal = '0;
        unique case (nextState)
            ST_HS_RQST:  timerVal = CNT_W'(T_LPX - 1);
            ST_HS_PREP:  timerVal = CNT_W'(T_HS_PREP - 1);
            ST_HS_ZERO:  timerVal = CNT_W'(T_HS_ZERO - 1);
            ST_HS_TRAIL: timerVal = CNT_W'(T_HS_TRAIL - 1);
            ST_HS_EXIT:  timerVal = CNT_W'(T_HS_EXIT - 1);
            default:     timerVal = '0;
        endcase
    end

    dphy_phase_timer #(
        .CNT_W(CNT_W)
    ) uTimer (
        .byteClk(TxByteClk),
        .rstN   (TxRst),
        .load   (timerLoad),
        .loadVal(timerVal),
        .expired(timerExpired)
    );

    // Trail drives the complement of the final payload bit.
    always_comb begin
        hsDataD = 8'h00;
        if (nextState == ST_HS_SYNC) begin
            hsDataD = SYNC_BYTE;
        end else if (accept) begin
            hsDataD = TxDataHS;
        end else if (nextState == ST_HS_TRAIL) begin
            hsDataD = {8{~lastBit}};
        end
    end

    always_ff @(posedge TxByteClk or negedge TxRst) begin
        if (!TxRst) begin
            state   <= ST_STOP;
            hsDataQ <= 8'h00;
            lastBit <= 1'b0;
        end else begin
            state   <= nextState;
            hsDataQ <= hsDataD;
            if (state == ST_STOP) begin
                lastBit <= 1'b0;
            end else if (accept) begin
                lastBit <= TxDataHS[7];
            end
        end
    end

    always_comb begin
        lpLevel = LP11;
        LptxEn  = 1'b1;
        HstxEn  = 1'b0;
        HsclkEn = 1'b0;
        unique case (state)
            ST_HS_RQST: lpLevel = LP01;
            ST_HS_PREP: begin
                lpLevel = LP00;
                HsclkEn = 1'b1;
            end
            ST_HS_ZERO, ST_HS_SYNC, ST_HS_DATA, ST_HS_TRAIL: begin
                lpLevel = LP00;
                LptxEn  = 1'b0;
                HstxEn  = 1'b1;
                HsclkEn = 1'b1;
            end
            default: ;
        endcase
    end

    assign {LpDp, LpDn} = lpLevel;
    assign HsData       = hsDataQ;
    assign DphyTxState  = state;
    assign TxStopState  = (state == ST_STOP);

endmodule

// File: tb/tb_dphy_hs_tx_sequencer.sv
// Scoreboard bench for the D-PHY HS sequencer: default timing and
// an all-minimum-timing instance.
module tb_dphy_hs_tx_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;
    logic req0, req1;
    logic [7:0] din0, din1;
    logic rdy0, dp0, dn0, lpen0, hsen0, clken0, stop0;
    logic rdy1, dp1, dn1, lpen1, hsen1, clken1, stop1;
    logic [7:0] hs0, hs1;
    logic [2:0] st0, st1;

    dphy_hs_tx_sequencer dut0 (
        .TxByteClk  (clk),
        .TxRst      (rstN),
        .TxRequestHS(req0),
        .TxDataHS   (din0),
        .TxReadyHS  (rdy0),
        .LpDp       (dp0),
        .LpDn       (dn0),
        .LptxEn     (lpen0),
        .HstxEn     (hsen0),
        .HsclkEn    (clken0),
        .HsData     (hs0),
        .DphyTxState(st0),
        .TxStopState(stop0)
    );

    dphy_hs_tx_sequencer #(
        .T_LPX     (1),
        .T_HS_PREP (1),
        .T_HS_ZERO (1),
        .T_HS_TRAIL(1),
        .T_HS_EXIT (1),
        .CNT_W     (1)
    ) dut1 (
        .TxByteClk  (clk),
        .TxRst      (rstN),
        .TxRequestHS(req1),
        .TxDataHS   (din1),
        .TxReadyHS  (rdy1),
        .LpDp       (dp1),
        .LpDn       (dn1),
        .LptxEn     (lpen1),
        .HstxEn     (hsen1),
        .HsclkEn    (clken1),
        .HsData     (hs1),
        .DphyTxState(st1),
        .TxStopState(stop1)
    );

    typedef struct packed {
        logic       req;
        logic [7:0] din;
        logic [2:0] st;
        logic [7:0] hs;
        logic       rdy;
    } rec_t;

    typedef logic [7:0] bq_t[$];

    rec_t sb[$];
    int checks = 0;
    int failures = 0;

    // {LpDp, LpDn, LptxEn, HstxEn, HsclkEn}
    function automatic logic [4:0] linesOf(input logic [2:0] s);
        case (s)
            3'd0, 3'd7: return 5'b11100;
            3'd1:       return 5'b01100;
            3'd2:       return 5'b00101;
            default:    return 5'b00011;
        endcase
    endfunction

    task automatic push(input logic rq, input logic [7:0] d,
                        input logic [2:0] s, input logic [7:0] h,
                        input logic r);
        rec_t e;
        e.req = rq;
        e.din = d;
        e.st  = s;
        e.hs  = h;
        e.rdy = r;
        sb.push_back(e);
    endtask

    task automatic addBurst(input bq_t b, input int tl, input int tp,
                            input int tz, input int tt, input int te,
                            input bit tailReq, input bit terminal);
        int n;
        logic [7:0] d0;
        logic pre;
        logic [7:0] trail;
        n = b.size();
        d0 = (n > 0) ? b[0] : 8'h5A;
        pre = (n > 0);
        trail = 8'hFF;
        if (n > 0) trail = b[n-1][7] ? 8'h00 : 8'hFF;
        push(1'b1, d0, 3'd0, 8'h00, 1'b0);
        repeat (tl) push(pre, d0, 3'd1, 8'h00, 1'b0);
        repeat (tp) push(pre, d0, 3'd2, 8'h00, 1'b0);
        repeat (tz) push(pre, d0, 3'd3, 8'h00, 1'b0);
        push(pre, d0, 3'd4, 8'hB8, 1'b0);
        for (int j = 0; j <= n; j++) begin
            push(j < n, (j < n) ? b[j] : 8'hC3, 3'd5,
                 (j == 0) ? 8'h00 : b[j-1], j < n);
        end
        repeat (tt) push(tailReq, 8'h99, 3'd6, trail, 1'b0);
        repeat (te) push(tailReq, 8'h99, 3'd7, 8'h00, 1'b0);
        if (terminal) push(1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
    endtask

    task automatic runSb(input bit sel, input string name);
        rec_t e;
        logic [2:0] st;
        logic [7:0] hs;
        logic rdy;
        logic stp;
        logic [4:0] ln;
        int cyc;
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge clk);
            #1;
            if (sel) begin
                req1 = e.req;
                din1 = e.din;
            end else begin
                req0 = e.req;
                din0 = e.din;
            end
            @(negedge clk);
            st  = sel ? st1 : st0;
            hs  = sel ? hs1 : hs0;
            rdy = sel ? rdy1 : rdy0;
            stp = sel ? stop1 : stop0;
            ln  = sel ? {dp1, dn1, lpen1, hsen1, clken1}
                      : {dp0, dn0, lpen0, hsen0, clken0};
            checks++;
            if (st !== e.st) begin
                failures++;
                $display("FAIL %s c%0d state: got %0d want %0d",
                         name, cyc, st, e.st);
            end
            checks++;
            if (hs !== e.hs) begin
                failures++;
                $display("FAIL %s c%0d HsData: got %h want %h",
                         name, cyc, hs, e.hs);
            end
            checks++;
            if (rdy !== e.rdy) begin
                failures++;
                $display("FAIL %s c%0d TxReadyHS: got %b want %b",
                         name, cyc, rdy, e.rdy);
            end
            checks++;
            if (ln !== linesOf(e.st)) begin
                failures++;
                $display("FAIL %s c%0d lines: got %b want %b",
                         name, cyc, ln, linesOf(e.st));
            end
            checks++;
            if (stp !== (e.st == 3'd0)) begin
                failures++;
                $display("FAIL %s c%0d TxStopState: got %b want %b",
                         name, cyc, stp, (e.st == 3'd0));
            end
            cyc++;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        din0 = 8'h00;
        din1 = 8'h00;
        #2 rstN = 1'b0;
        #10;
        checks++;
        if ({dp0, dn0, lpen0, hsen0, clken0} !== 5'b11100) begin
            failures++;
            $display("FAIL reset lines: got %b want 11100",
                     {dp0, dn0, lpen0, hsen0, clken0});
        end
        checks++;
        if ({st0, stop0, rdy0, hs0} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset state: got %h want %h",
                     {st0, stop0, rdy0, hs0}, {3'd0, 1'b1, 1'b0, 8'h00});
        end
        checks++;
        if ({st1, stop1, hsen1, hs1} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset dut1: got %h want %h",
                     {st1, stop1, hsen1, hs1}, {3'd0, 1'b1, 1'b0, 8'h00});
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_idle();
        repeat (20) push(1'b0, 8'h00, 3'd0, 8'h00, 1'b0);
        runSb(1'b0, "idle");
    endtask

    task automatic test_burst();
        addBurst('{8'hA5, 8'h3C, 8'h81}, 2, 2, 6, 3, 4, 1'b0, 1'b1);
        runSb(1'b0, "burst3");
    endtask

    task automatic test_trail_ones();
        addBurst('{8'h12, 8'h7F}, 2, 2, 6, 3, 4, 1'b0, 1'b1);
        runSb(1'b0, "trail_ff");
    endtask

    task automatic test_pulse();
        bq_t none;
        none = {};
        addBurst(none, 2, 2, 6, 3, 4, 1'b0, 1'b1);
        runSb(1'b0, "pulse");
    endtask

    task automatic test_reset_mid_burst();
        int k;
        k = 0;
        @(posedge clk);
        #1;
        req0 = 1'b1;
        din0 = 8'h11;
        while (st0 !== 3'd5 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (st0 !== 3'd5) begin
            failures++;
            $display("FAIL rst_mid reach_data: got %0d want 5", st0);
        end
        #2 rstN = 1'b0;
        #1;
        checks++;
        if ({dp0, dn0, lpen0, hsen0, clken0} !== 5'b11100) begin
            failures++;
            $display("FAIL rst_mid lines: got %b want 11100",
                     {dp0, dn0, lpen0, hsen0, clken0});
        end
        checks++;
        if ({st0, stop0, rdy0, hs0} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL rst_mid state: got %h want %h",
                     {st0, stop0, rdy0, hs0}, {3'd0, 1'b1, 1'b0, 8'h00});
        end
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        addBurst('{8'h6E}, 2, 2, 6, 3, 4, 1'b0, 1'b1);
        runSb(1'b0, "after_rst");
    endtask

    task automatic test_rerequest();
        addBurst('{8'h44, 8'hE0}, 2, 2, 6, 3, 4, 1'b1, 1'b0);
        addBurst('{8'h37}, 2, 2, 6, 3, 4, 1'b0, 1'b1);
        runSb(1'b0, "rerequest");
    endtask

    task automatic test_min_timing();
        bq_t none;
        none = {};
        addBurst('{8'h01, 8'hFE, 8'h80}, 1, 1, 1, 1, 1, 1'b0, 1'b1);
        addBurst(none, 1, 1, 1, 1, 1, 1'b0, 1'b1);
        addBurst('{8'hD2}, 1, 1, 1, 1, 1, 1'b1, 1'b0);
        addBurst('{8'h2B, 8'h9C}, 1, 1, 1, 1, 1, 1'b0, 1'b1);
        runSb(1'b1, "min_t");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_burst();
        test_trail_ones();
        test_pulse();
        test_reset_mid_burst();
        test_rerequest();
        test_min_timing();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
